clock_set_controller: RTL and testbench

Set-mode sequencer for the digital clock. It turns raw pushbutton levels (mode/up/down) into a field-selection state machine, single-cycle up/down strobes with hold-to-repeat, and the `manual_set` qualifier consumed by the hour/minute/day/month/year counters. It also computes `max_day` (including Gregorian leap years) for the day counter, and drops back to run mode after an idle timeout.

---
 rtl/clock_set_controller_if.sv | 35 +++
 rtl/clock_set_controller.sv | 212 +++++++++++++++++++++
 tb/tb_clock_set_controller.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_set_controller_if.sv
// Button, calendar and set-mode signals exchanged between the clock UI and
// the set-mode sequencer. The UI side drives the buttons and the current
// calendar date; the sequencer drives the field selection and strobes.
interface clock_set_controller_if;
    // Button levels and the one-second tick, already synchronized/debounced
    logic       mode_btn;
    logic       up_btn;
    logic       down_btn;
    logic       tick_1hz;

    // Current calendar position, used only for the days-in-month lookup
    logic [3:0]  month;
    logic [13:0] year;

    // Set-mode qualifiers and strobes consumed by the time/date counters
    logic        manual_set;
    logic [2:0]  field_sel;
    logic        up;
    logic        down;
    logic        sec_clear;
    logic        blink_en;
    logic [5:0]  max_day;

    // UI / environment side
    modport master (
        output mode_btn, up_btn, down_btn, tick_1hz, month, year,
        input  manual_set, field_sel, up, down, sec_clear, blink_en, max_day
    );

    // Sequencer side
    modport slave (
        input  mode_btn, up_btn, down_btn, tick_1hz, month, year,
        output manual_set, field_sel, up, down, sec_clear, blink_en, max_day
    );
endinterface

// File: rtl/clock_set_controller.sv
// Set-mode sequencer for the digital clock.
// Walks RUN -> SET_HOUR -> SET_MIN -> SET_DAY -> SET_MONTH -> SET_YEAR -> RUN
// on mode-button presses, turns up/down button levels into single-cycle
// strobes with hold-to-repeat, drops back to RUN after an idle timeout, and
// supplies the days-in-month limit for the day counter.
module clock_set_controller #(
    parameter logic [23:0] HOLD_CYCLES   = 24'd5_000_000,
    parameter logic [23:0] REPEAT_CYCLES = 24'd1_000_000,
    parameter logic [5:0]  TIMEOUT_TICKS = 6'd30
) (
    input  logic                    clk,
    input  logic                    rst_n,
    clock_set_controller_if.slave   cs
);

    // State encoding doubles as the field_sel code driven to the counters
    localparam logic [2:0] ST_RUN       = 3'd0;
    localparam logic [2:0] ST_SET_HOUR  = 3'd1;
    localparam logic [2:0] ST_SET_MIN   = 3'd2;
    localparam logic [2:0] ST_SET_DAY   = 3'd3;
    localparam logic [2:0] ST_SET_MONTH = 3'd4;
    localparam logic [2:0] ST_SET_YEAR  = 3'd5;

    // Per-button repeat tracker. 'strobe' is the registered up/down output,
    // 'active' means the current hold started with an accepted press,
    // 'repeating' selects between the initial hold and the repeat interval.
    typedef struct packed {
        logic        strobe;
        logic        active;
        logic        repeating;
        logic [23:0] cnt;
    } rpt_t;

    logic [2:0] state;
    logic [2:0] next_state;
    logic       mode_prev;
    logic       up_prev;
    logic       down_prev;
    rpt_t       up_q;
    rpt_t       down_q;
    rpt_t       up_n;
    rpt_t       down_n;
    logic [5:0] idle_cnt;
    logic [5:0] idle_n;

    logic       mode_rise;
    logic       up_rise;
    logic       down_rise;
    logic       any_rise;
    logic       in_set;
    logic       strobe_block;
    logic       strobe_any;
    logic       timeout_hit;

    // Next field in the set-mode rotation; SET_YEAR wraps back to RUN
    function automatic logic [2:0] advance(input logic [2:0] s);
        logic [2:0] n;
        case (s)
            ST_RUN:       n = ST_SET_HOUR;
            ST_SET_HOUR:  n = ST_SET_MIN;
            ST_SET_MIN:   n = ST_SET_DAY;
            ST_SET_DAY:   n = ST_SET_MONTH;
            ST_SET_MONTH: n = ST_SET_YEAR;
            default:      n = ST_RUN;
        endcase
        return n;
    endfunction

    // One clock of the hold-to-repeat tracker for a single button.
    // A press strobes at once; the first repeat fires HOLD_CYCLES clocks
    // later and subsequent ones every REPEAT_CYCLES clocks. Counting only
    // continues from an accepted press, so a button held across a mode
    // change or a two-button chord stays silent until pressed again.
    function automatic rpt_t rpt_step(input logic btn, input logic rise,
                                      input logic blocked, input rpt_t cur);
        rpt_t nxt;
        nxt        = cur;
        nxt.strobe = 1'b0;
        if (blocked || !btn) begin
            nxt.active    = 1'b0;
            nxt.repeating = 1'b0;
            nxt.cnt       = '0;
        end else if (rise) begin
            nxt.strobe    = 1'b1;
            nxt.active    = 1'b1;
            nxt.repeating = 1'b0;
            nxt.cnt       = 24'd1;
        end else if (cur.active) begin
            if (!cur.repeating && cur.cnt >= HOLD_CYCLES) begin
                nxt.strobe    = 1'b1;
                nxt.repeating = 1'b1;
                nxt.cnt       = 24'd1;
            end else if (cur.repeating && cur.cnt >= REPEAT_CYCLES) begin
                nxt.strobe = 1'b1;
                nxt.cnt    = 24'd1;
            end else begin
                nxt.cnt = cur.cnt + 24'd1;
            end
        end
        return nxt;
    endfunction

    // Days in the given month; February follows the Gregorian leap rule and
    // any out-of-range month falls back to 31 so the day counter never stalls
    function automatic logic [5:0] days_in_month(input logic [3:0] m,
                                                 input logic [13:0] y);
        logic       leap;
        logic [5:0] d;
        leap = (((y % 14'd4) == 14'd0) && ((y % 14'd100) != 14'd0))
               || ((y % 14'd400) == 14'd0);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: d = 6'd30;
            4'd2:                    d = leap ? 6'd29 : 6'd28;
            default:                 d = 6'd31;
        endcase
        return d;
    endfunction

    assign mode_rise = cs.mode_btn & ~mode_prev;
    assign up_rise   = cs.up_btn   & ~up_prev;
    assign down_rise = cs.down_btn & ~down_prev;
    assign any_rise  = mode_rise | up_rise | down_rise;
    assign in_set    = (state != ST_RUN);

    // Strobes are suppressed outside set mode, on a mode transition (mode
    // wins) and while both up and down are held together
    assign strobe_block = !in_set || mode_rise || (cs.up_btn && cs.down_btn);

    // Next-state, repeat trackers and idle timeout
    always_comb begin
        // NOTE: every combinational output is given a default before any
        // branch so no path leaves it unassigned and no latch is inferred.
        next_state  = state;
        idle_n      = idle_cnt;
        timeout_hit = 1'b0;

        up_n       = rpt_step(cs.up_btn,   up_rise,   strobe_block, up_q);
        down_n     = rpt_step(cs.down_btn, down_rise, strobe_block, down_q);
        strobe_any = up_n.strobe | down_n.strobe;

        if (!in_set) begin
            idle_n = '0;
        end else if (any_rise || strobe_any) begin
            idle_n = '0;
        end else if (cs.tick_1hz) begin
            if (({1'b0, idle_cnt} + 7'd1) >= {1'b0, TIMEOUT_TICKS}) begin
                timeout_hit = 1'b1;
                idle_n      = '0;
            end else begin
                idle_n = idle_cnt + 6'd1;
            end
        end

        if (mode_rise) begin
            next_state = advance(state);
        end else if (timeout_hit) begin
            next_state = ST_RUN;
        end
    end

    // State, edge-detect history, repeat trackers and idle counter
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            state     <= ST_RUN;
            mode_prev <= 1'b0;
            up_prev   <= 1'b0;
            down_prev <= 1'b0;
            up_q      <= '0;
            down_q    <= '0;
            idle_cnt  <= '0;
        end else begin
            state     <= next_state;
            mode_prev <= cs.mode_btn;
            up_prev   <= cs.up_btn;
            down_prev <= cs.down_btn;
            up_q      <= up_n;
            down_q    <= down_n;
            idle_cnt  <= idle_n;
        end
    end

    // Registered set-mode outputs; sec_clear fires in the first cycle that
    // field_sel shows SET_HOUR, which is only ever entered from RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs.field_sel  <= ST_RUN;
            cs.manual_set <= 1'b0;
            cs.blink_en   <= 1'b0;
            cs.sec_clear  <= 1'b0;
        end else begin
            cs.field_sel  <= state;
            cs.manual_set <= in_set;
            cs.blink_en   <= in_set;
            cs.sec_clear  <= (state == ST_SET_HOUR) && (cs.field_sel != ST_SET_HOUR);
        end
    end

    // Registered days-in-month limit for the day counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs.max_day <= 6'd31;
        end else begin
            cs.max_day <= days_in_month(cs.month, cs.year);
        end
    end

    assign cs.up   = up_q.strobe;
    assign cs.down = down_q.strobe;

endmodule

// File: tb/tb_clock_set_controller.sv
// Scoreboard bench for clock_set_controller. Stimulus pushes each expected
// output event (field change, sec_clear, up/down strobe, max_day change)
// with the cycle it must appear on; a monitor pops and compares every event
// the DUT actually produces.
module tb_clock_set_controller;

    localparam logic [23:0] HOLD    = 24'd10;
    localparam logic [23:0] REPEAT  = 24'd4;
    localparam logic [5:0]  TIMEOUT = 6'd3;

    localparam logic [2:0] EV_FSEL   = 3'd0;
    localparam logic [2:0] EV_SECCLR = 3'd1;
    localparam logic [2:0] EV_UP     = 3'd2;
    localparam logic [2:0] EV_DOWN   = 3'd3;
    localparam logic [2:0] EV_MAXDAY = 3'd4;

    typedef struct {
        logic [2:0] kind;
        int         cyc;
        int         val;
    } ev_t;

    ev_t  exp_q[$];
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc        = 0;
    int   checks     = 0;
    int   errors     = 0;
    int   strobe_cnt = 0;
    bit   mon_en     = 1'b0;
    int   exp_fsel   = 0;
    int   exp_maxday = 31;

    clock_set_controller_if cs();

    clock_set_controller #(
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REPEAT),
        .TIMEOUT_TICKS (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cs    (cs)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic observe(input logic [2:0] kind, input int val);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: kind %0d value %0d at cycle %0d, none expected",
                     kind, val, cyc);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            check("event_cycle", cyc, e.cyc);
            check("event_value", val, e.val);
        end
    endtask

    // Monitor: every output event the DUT presents is matched against the queue
    initial begin : monitor
        int prev_fsel;
        int prev_md;
        prev_fsel = 0;
        prev_md   = 31;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (int'(cs.field_sel) != prev_fsel) begin
                    prev_fsel = int'(cs.field_sel);
                    observe(EV_FSEL, prev_fsel);
                end
                if (cs.sec_clear) observe(EV_SECCLR, 1);
                if (cs.up) begin
                    strobe_cnt++;
                    observe(EV_UP, 1);
                end
                if (cs.down) begin
                    strobe_cnt++;
                    observe(EV_DOWN, 1);
                end
                if (int'(cs.max_day) != prev_md) begin
                    prev_md = int'(cs.max_day);
                    observe(EV_MAXDAY, prev_md);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(input logic [2:0] kind, input int dc, input int val);
        ev_t e;
        e.kind = kind;
        e.cyc  = cyc + dc;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Mode press: field_sel (and sec_clear on entering SET_HOUR) appear two
    // clocks after the button is driven
    task automatic press_mode();
        exp_fsel = (exp_fsel == 5) ? 0 : exp_fsel + 1;
        expect_ev(EV_FSEL, 2, exp_fsel);
        if (exp_fsel == 1) expect_ev(EV_SECCLR, 2, 1);
        cs.mode_btn = 1'b1;
        step(2);
        check("manual_set", cs.manual_set, exp_fsel != 0);
        check("blink_en", cs.blink_en, exp_fsel != 0);
        cs.mode_btn = 1'b0;
        step(2);
    endtask

    task automatic pulse_tick();
        cs.tick_1hz = 1'b1;
        step(1);
        cs.tick_1hz = 1'b0;
        step(3);
    endtask

    task automatic set_date(input logic [3:0] m, input logic [13:0] y, input int days);
        if (days != exp_maxday) expect_ev(EV_MAXDAY, 1, days);
        exp_maxday = days;
        cs.month   = m;
        cs.year    = y;
        step(2);
        check("max_day", cs.max_day, days);
    endtask

    task automatic check_reset_outputs();
        check("rst_field_sel", cs.field_sel, 0);
        check("rst_manual_set", cs.manual_set, 0);
        check("rst_blink_en", cs.blink_en, 0);
        check("rst_up", cs.up, 0);
        check("rst_down", cs.down, 0);
        check("rst_sec_clear", cs.sec_clear, 0);
        check("rst_max_day", cs.max_day, 31);
    endtask

    initial begin : stimulus
        int s;
        cs.mode_btn = 1'b0;
        cs.up_btn   = 1'b0;
        cs.down_btn = 1'b0;
        cs.tick_1hz = 1'b0;
        cs.month    = 4'd1;
        cs.year     = 14'd2024;
        rst_n       = 1'b0;
        step(3);
        check_reset_outputs();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step(2);

        // Buttons in RUN produce nothing
        s = strobe_cnt;
        cs.up_btn = 1'b1;   step(5);
        cs.up_btn = 1'b0;   step(2);
        cs.down_btn = 1'b1; step(5);
        cs.down_btn = 1'b0; step(3);
        check("run_no_strobe", strobe_cnt, s);

        // Full rotation through all set fields back to RUN
        repeat (6) press_mode();

        // Up and down held together in SET_MIN
        press_mode();
        press_mode();
        s = strobe_cnt;
        cs.up_btn   = 1'b1;
        cs.down_btn = 1'b1;
        step(20);
        cs.up_btn   = 1'b0;
        cs.down_btn = 1'b0;
        step(3);
        check("chord_no_strobe", strobe_cnt, s);

        // Hold-to-repeat in SET_DAY: strobes at +1, +11, +15, +19, +23, +27
        press_mode();
        expect_ev(EV_UP, 1, 1);
        expect_ev(EV_UP, 11, 1);
        expect_ev(EV_UP, 15, 1);
        expect_ev(EV_UP, 19, 1);
        expect_ev(EV_UP, 23, 1);
        expect_ev(EV_UP, 27, 1);
        cs.up_btn = 1'b1;
        step(30);
        cs.up_btn = 1'b0;
        step(10);

        // Single down press
        expect_ev(EV_DOWN, 1, 1);
        cs.down_btn = 1'b1;
        step(3);
        cs.down_btn = 1'b0;
        step(3);

        // Days-in-month table and leap years
        set_date(4'd2,  14'd2024, 29);
        set_date(4'd2,  14'd1900, 28);
        set_date(4'd2,  14'd2000, 29);
        set_date(4'd2,  14'd2023, 28);
        set_date(4'd12, 14'd2023, 31);
        set_date(4'd4,  14'd2023, 30);
        set_date(4'd0,  14'd2023, 31);

        // Idle timeout from SET_YEAR after three ticks
        press_mode();
        press_mode();
        pulse_tick();
        pulse_tick();
        exp_fsel = 0;
        expect_ev(EV_FSEL, 2, 0);
        pulse_tick();
        check("timeout_manual_set", cs.manual_set, 0);

        // An up press after two ticks restarts the idle count
        repeat (5) press_mode();
        pulse_tick();
        pulse_tick();
        expect_ev(EV_UP, 1, 1);
        cs.up_btn = 1'b1;
        step(2);
        cs.up_btn = 1'b0;
        step(2);
        pulse_tick();
        check("no_timeout_after_press", cs.field_sel, 5);
        pulse_tick();
        exp_fsel = 0;
        expect_ev(EV_FSEL, 2, 0);
        pulse_tick();

        // Asynchronous reset during auto-repeat in SET_HOUR
        press_mode();
        expect_ev(EV_UP, 1, 1);
        expect_ev(EV_UP, 11, 1);
        cs.up_btn = 1'b1;
        step(13);
        exp_fsel = 0;
        expect_ev(EV_FSEL, 1, 0);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs();
        step(3);
        rst_n = 1'b1;
        s = strobe_cnt;
        step(20);
        cs.up_btn = 1'b0;
        step(3);
        check("post_reset_no_strobe", strobe_cnt, s);
        check("post_reset_field_sel", cs.field_sel, 0);

        step(5);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
